score_engine: RTL
=================

Name: score_engine

Overview:
- Parametrised successor to the single-channel game score counter.
- Sums per-lane hit judgements across LANES note lanes and tracks combo with a capped tier multiplier; score and combo saturate.
- Latches the final score at song end and keeps a session high score.
- Sits between the note-judgement logic and the LED-matrix score display; driven by the top-level game_state.

Parameters:
- LANES, 2, number of note lanes.
- SCORE_W, 16, score, final and high-score width.
- COMBO_W, 8, combo counter width.
- PTS_GOOD, 1, points for a good hit.
- PTS_PERFECT, 2, points for a perfect hit.
- TIER_LOG2, 4, log2 of combo hits per multiplier tier (16).
- MULT_MAX, 17, multiplier ceiling.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- game_state  in  2  0=IDLE, 1=SONG_SELECT, 2=GAME_PLAY, 3=GAME_OVER.
- lane_hit  in  LANES  per-lane hit strobe, one cycle per note.
- lane_perfect  in  LANES  qualifies lane_hit: 1=perfect, 0=good.
- lane_miss  in  LANES  per-lane miss strobe.
- score  out  SCORE_W  running score.
- combo  out  COMBO_W  current combo.
- max_combo  out  COMBO_W  best combo this song.
- multiplier  out  MULT_W=$clog2(MULT_MAX+1)  current multiplier.
- high_score  out  SCORE_W  best final score since reset.
- new_high  out  1  level: last final score beat high_score.
- done  out  1  one-cycle pulse on song end.
- playing  out  1  FSM in PLAY.

Behaviour:
- Interface: one clock clk; reset rst_n asynchronous, active-low.
- Reset values (asynchronous, immediate): score=0, combo=0, max_combo=0, high_score=0, multiplier=1, new_high=0, done=0, playing=0, FSM=IDLE, stage-1 invalid.

- FSM is evaluated on the raw game_state each edge:
  - IDLE: go to PLAY when game_state==GAME_PLAY.
  - OVER: go to PLAY when game_state==GAME_PLAY; go to IDLE on IDLE or SONG_SELECT; otherwise stay in OVER.
  - PLAY: go to DRAIN when game_state!=GAME_PLAY.
  - DRAIN: go to OVER unconditionally after one cycle.
- Entry to PLAY clears score, combo and max_combo; high_score and new_high are retained.
- On the DRAIN->OVER edge:
  - done=1 for exactly one cycle.
  - If score>high_score: high_score<=score and new_high<=1; otherwise new_high<=0.
- Outside PLAY the lane inputs are ignored. In IDLE and OVER, score is held (not cleared).

- Stage 1 (registered) samples the lanes when game_state==GAME_PLAY and FSM is PLAY or entering PLAY:
  - Per lane, miss wins over hit: that lane scores 0 and sets the miss flag.
  - base_sum = sum of PTS_PERFECT or PTS_GOOD over the non-missed hit lanes.
  - hit_cnt = number of non-missed hit lanes.
  - any_miss = OR of the per-lane miss flags.
  - s1_valid is set when any lane hit or missed.
- Stage 2 commits when s1_valid is set, including a commit that lands on the DRAIN cycle:
  - add = base_sum * multiplier, using the multiplier from the pre-update combo.
  - score <= min(score+add, 2^SCORE_W-1). Compute in SCORE_W+1+product bits so the sum cannot wrap.
  - If any_miss: combo<=0. Else combo <= min(combo+hit_cnt, 2^COMBO_W-1).
  - max_combo <= max(max_combo, new combo).
- Multiplier, registered from combo:
  - combo==0 gives 1.
  - Otherwise min(((combo-1)>>TIER_LOG2)+2, MULT_MAX).
- Latency: a lane strobe in cycle t is visible on score and combo after the edge ending cycle t+1; multiplier follows one cycle later.
- A miss and hits in the same cycle: the hits score at the old multiplier, then combo resets to 0.
- Back-to-back strobes every cycle are fully supported; there is no stall.

Decomposition:
- Package score_pkg holds:
  - game_state encodings GS_IDLE, GS_SONG_SELECT, GS_GAME_PLAY, GS_GAME_OVER;
  - the FSM state enum (IDLE, PLAY, DRAIN, OVER);
  - saturating add/max helper functions.
- One sub-module, combo_tier: combinational mapping combo to multiplier, parametrised by COMBO_W, TIER_LOG2 and MULT_MAX.

Test Plan:
1. Reset, then GAME_PLAY; lane_hit=11, lane_perfect=11 for one cycle -> two edges later score=4, combo=2; next cycle multiplier=2.
2. 17 single-lane good hits (lane_hit=01, perfect=0), one per cycle -> score=33 (1x1 + 16x2), combo=17, multiplier=3.
3. From test 2 state, lane_hit=01, perfect=01, lane_miss=10 in one cycle -> score=39, combo=0, max_combo=17, multiplier back to 1.
4. Overrides SCORE_W=8, COMBO_W=4: continuous 2-lane perfect hits -> combo sticks at 15, multiplier sticks at 2, score saturates at 255 and never wraps.
5. Song end: final hit in the last PLAY cycle, then GAME_OVER -> hit committed, done high for exactly 1 cycle, high_score=score, new_high=1. Replay with a lower score -> score cleared at PLAY entry, high_score unchanged, new_high=0.
6. rst_n asserted mid-song with hits in flight -> all outputs go to reset values immediately, with no clock edge. After release, a stale stage-1 hit must not commit.

Source files
------------

// File: rtl/score_pkg.sv
// Shared encodings and saturating helpers for the score engine.
package score_pkg;

    // Top-level game_state encodings
    localparam logic [1:0] GS_IDLE        = 2'd0;
    localparam logic [1:0] GS_SONG_SELECT = 2'd1;
    localparam logic [1:0] GS_GAME_PLAY   = 2'd2;
    localparam logic [1:0] GS_GAME_OVER   = 2'd3;

    typedef enum logic [1:0] {IDLE, PLAY, DRAIN, OVER} fsm_t;

    // Helpers work on a wide unsigned type so callers' sums cannot wrap;
    // callers cast back down after clamping to their own limit.
    typedef logic [63:0] wide_t;

    function automatic wide_t sat_add(input wide_t a, input wide_t b, input wide_t lim);
        wide_t s;
        s = a + b;
        return (s > lim) ? lim : s;
    endfunction

    function automatic wide_t max_u(input wide_t a, input wide_t b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/score_engine_combo_tier.sv
// Combo -> multiplier tier map: 1 at zero combo, else one step per
// 2^TIER_LOG2 hits starting at 2, capped at MULT_MAX.
module combo_tier #(
    parameter int COMBO_W   = 8,
    parameter int TIER_LOG2 = 4,
    parameter int MULT_MAX  = 17,
    parameter int MULT_W    = $clog2(MULT_MAX + 1)
) (
    input  logic [COMBO_W-1:0] combo,
    output logic [MULT_W-1:0]  mult
);
    // one extra bit so the +2 cannot overflow
    localparam int TW = COMBO_W + 1;

    logic [TW-1:0] dec;
    logic [TW-1:0] tier;

    // tier lookup with ceiling clamp
    always_comb begin
        dec  = {1'b0, combo} - TW'(1);
        tier = (dec >> TIER_LOG2) + TW'(2);
        if (combo == '0)
            mult = MULT_W'(1);
        else if (int'(tier) >= MULT_MAX)
            mult = MULT_W'(MULT_MAX);
        else
            mult = MULT_W'(tier);
    end

endmodule

// File: rtl/score_engine.sv
// Multi-lane score/combo engine: stage 1 registers per-lane judgements,
// stage 2 commits points at the current combo tier. Tracks song end and
// a session high score.
module score_engine
    import score_pkg::*;
#(
    parameter int LANES       = 2,
    parameter int SCORE_W     = 16,
    parameter int COMBO_W     = 8,
    parameter int PTS_GOOD    = 1,
    parameter int PTS_PERFECT = 2,
    parameter int TIER_LOG2   = 4,
    parameter int MULT_MAX    = 17,
    localparam int MULT_W     = $clog2(MULT_MAX + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [1:0]         game_state,
    input  logic [LANES-1:0]   lane_hit,
    input  logic [LANES-1:0]   lane_perfect,
    input  logic [LANES-1:0]   lane_miss,
    output logic [SCORE_W-1:0] score,
    output logic [COMBO_W-1:0] combo,
    output logic [COMBO_W-1:0] max_combo,
    output logic [MULT_W-1:0]  multiplier,
    output logic [SCORE_W-1:0] high_score,
    output logic               new_high,
    output logic               done,
    output logic               playing
);
    localparam int PTS_MAX = (PTS_PERFECT > PTS_GOOD) ? PTS_PERFECT : PTS_GOOD;
    localparam int BASE_W  = $clog2(LANES * PTS_MAX + 1);
    localparam int CNT_W   = $clog2(LANES + 1);
    localparam int PROD_W  = BASE_W + MULT_W;
    localparam logic [SCORE_W-1:0] SCORE_MAX = {SCORE_W{1'b1}};
    localparam logic [COMBO_W-1:0] COMBO_MAX = {COMBO_W{1'b1}};

    typedef struct packed {
        logic              valid;
        logic [BASE_W-1:0] base_sum;
        logic [CNT_W-1:0]  hit_cnt;
        logic              any_miss;
    } s1_t;

    fsm_t                          state;
    s1_t                           s1, s1_nx;
    logic [LANES-1:0]              lane_ok;
    logic [LANES-1:0][BASE_W-1:0]  lane_pts;
    logic [MULT_W-1:0]             mult_now;
    logic [PROD_W-1:0]             add;
    logic [SCORE_W-1:0]            score_nx;
    logic [COMBO_W-1:0]            combo_nx;
    logic                          play_entry;
    logic                          sample_en;

    // entering PLAY this edge; lanes are live on this edge too
    assign play_entry = (game_state == GS_GAME_PLAY) && (state == IDLE || state == OVER);
    assign sample_en  = (game_state == GS_GAME_PLAY) && (state == PLAY || play_entry);

    // per-lane points; a miss on a lane cancels its hit
    for (genvar g = 0; g < LANES; g++) begin : g_lane
        assign lane_ok[g]  = lane_hit[g] & ~lane_miss[g];
        assign lane_pts[g] = !lane_ok[g]      ? '0 :
                             lane_perfect[g]  ? BASE_W'(PTS_PERFECT) : BASE_W'(PTS_GOOD);
    end

    // reduce lanes into one stage-1 record
    always_comb begin
        s1_nx          = '0;
        s1_nx.valid    = |(lane_hit | lane_miss);
        s1_nx.any_miss = |lane_miss;
        for (int i = 0; i < LANES; i++) begin
            s1_nx.base_sum = s1_nx.base_sum + lane_pts[i];
            s1_nx.hit_cnt  = s1_nx.hit_cnt + CNT_W'(lane_ok[i]);
        end
    end

    // stage-1 register; cleared whenever lanes are not being sampled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            s1 <= '0;
        else
            s1 <= sample_en ? s1_nx : '0;
    end

    // tier from the pre-update combo, so same-cycle misses score at the old rate
    combo_tier #(
        .COMBO_W   (COMBO_W),
        .TIER_LOG2 (TIER_LOG2),
        .MULT_MAX  (MULT_MAX),
        .MULT_W    (MULT_W)
    ) u_tier (
        .combo (combo),
        .mult  (mult_now)
    );

    // stage-2 next values, saturating
    always_comb begin
        add      = PROD_W'(s1.base_sum) * PROD_W'(mult_now);
        score_nx = SCORE_W'(sat_add(wide_t'(score), wide_t'(add), wide_t'(SCORE_MAX)));
        combo_nx = s1.any_miss ? '0 :
                   COMBO_W'(sat_add(wide_t'(combo), wide_t'(s1.hit_cnt), wide_t'(COMBO_MAX)));
    end

    // running score/combo: cleared on PLAY entry, committed on valid stage 1
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            score     <= '0;
            combo     <= '0;
            max_combo <= '0;
        end else if (play_entry) begin
            score     <= '0;
            combo     <= '0;
            max_combo <= '0;
        end else if (s1.valid) begin
            score     <= score_nx;
            combo     <= combo_nx;
            max_combo <= COMBO_W'(max_u(wide_t'(max_combo), wide_t'(combo_nx)));
        end
    end

    // displayed multiplier trails combo by one cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            multiplier <= MULT_W'(1);
        else
            multiplier <= mult_now;
    end

    // song FSM with registered status outputs and high-score latch
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            done       <= 1'b0;
            playing    <= 1'b0;
            high_score <= '0;
            new_high   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (game_state == GS_GAME_PLAY) begin
                        state   <= PLAY;
                        playing <= 1'b1;
                    end
                end
                PLAY: begin
                    if (game_state != GS_GAME_PLAY) begin
                        state   <= DRAIN;
                        playing <= 1'b0;
                    end
                end
                DRAIN: begin
                    // last in-flight hit committed on the previous edge
                    state <= OVER;
                    done  <= 1'b1;
                    if (score > high_score) begin
                        high_score <= score;
                        new_high   <= 1'b1;
                    end else begin
                        new_high   <= 1'b0;
                    end
                end
                OVER: begin
                    if (game_state == GS_GAME_PLAY) begin
                        state   <= PLAY;
                        playing <= 1'b1;
                    end else if (game_state == GS_IDLE || game_state == GS_SONG_SELECT) begin
                        state   <= IDLE;
                    end
                end
                default: begin
                    state   <= IDLE;
                    playing <= 1'b0;
                end
            endcase
        end
    end

endmodule
